// File: rtl/pl_sysref_pkg.sv
// pl_sysref_pkg: shared state enum, constants and period/high-time clamp helpers for pl_sysref_gen
package pl_sysref_pkg;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} sysref_gen_state_e;
  localparam logic [31:0] PERIOD_MIN = 32'd2;
  localparam int COUNT_CONTINUOUS = 0;
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < PERIOD_MIN) ? PERIOD_MIN : p;
  endfunction
  function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] p);
    return (h == 32'd0) ? 32'd1 : (h >= p) ? p - 32'd1 : h;
  endfunction
endpackage

// File: rtl/pl_sysref_edge_det.sv
// pl_sysref_edge_det: 2-flop synchroniser plus rising-edge detect; ports pl_clk, pl_rst, din, rise
module pl_sysref_edge_det (
  input  logic pl_clk,
  input  logic pl_rst,
  input  logic din,
  output logic rise
);
  logic s1, s2, s2_d;
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s2_d <= s2;
    end
  end
  assign rise = s2 & ~s2_d;
endmodule

// File: rtl/pl_sysref_gen.sv
// pl_sysref_gen: SYSREF burst/continuous pulse generator; in pl_clk pl_rst cfg_period cfg_high cfg_count start stop sysref_ref(SYSREF_ALIGN_EN), out sysref_out busy done pulse_cnt
module pl_sysref_gen
  import pl_sysref_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_high,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic                start,
  input  logic                stop,
`ifdef SYSREF_ALIGN_EN
  input  logic                sysref_ref,
`endif
  output logic                sysref_out,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pulse_cnt
);
  sysref_gen_state_e state;
  logic [PERIOD_W-1:0] p_c, h_c, p_last, h_last, ph;
  logic [CNT_W-1:0] n_r;
  logic stop_pend, last_pulse;
`ifdef SYSREF_ALIGN_EN
  logic ref_rise;
  pl_sysref_edge_det u_edge (
    .pl_clk(pl_clk),
    .pl_rst(pl_rst),
    .din(sysref_ref),
    .rise(ref_rise)
  );
`endif
  always_comb begin
    p_c = PERIOD_W'(clamp_period(32'(cfg_period)));
    h_c = PERIOD_W'(clamp_high(32'(cfg_high), 32'(p_c)));
    last_pulse = stop_pend || (n_r != CNT_W'(COUNT_CONTINUOUS) && pulse_cnt == n_r);
  end
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      state <= IDLE;
      sysref_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pulse_cnt <= '0;
      stop_pend <= 1'b0;
      ph <= '0;
      p_last <= '0;
      h_last <= '0;
      n_r <= '0;
    end else begin
      done <= 1'b0;
      if (stop && busy) stop_pend <= 1'b1;
      case (state)
        IDLE: if (start && !stop) begin
          p_last <= p_c - PERIOD_W'(1);
          h_last <= h_c - PERIOD_W'(1);
          n_r <= cfg_count;
          busy <= 1'b1;
          ph <= '0;
          stop_pend <= 1'b0;
`ifdef SYSREF_ALIGN_EN
          state <= ARM;
          pulse_cnt <= '0;
`else
          state <= HIGH;
          sysref_out <= 1'b1;
          pulse_cnt <= CNT_W'(1);
`endif
        end
`ifdef SYSREF_ALIGN_EN
        ARM: if (stop) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          stop_pend <= 1'b0;
        end else if (ref_rise) begin
          state <= HIGH;
          sysref_out <= 1'b1;
          pulse_cnt <= CNT_W'(1);
          ph <= '0;
        end
`endif
        HIGH: begin
          ph <= ph + PERIOD_W'(1);
          if (ph == h_last) begin
            state <= LOW;
            sysref_out <= 1'b0;
          end
        end
        LOW: if (ph != p_last) ph <= ph + PERIOD_W'(1);
        else begin
          ph <= '0;
          if (last_pulse) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            stop_pend <= 1'b0;
          end else begin
            state <= HIGH;
            sysref_out <= 1'b1;
            pulse_cnt <= pulse_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pl_sysref_gen.sv
// tb_pl_sysref_gen: table-driven checks of pl_sysref_gen bursts, stop, clamping, reset and optional SYSREF_ALIGN_EN arming
module tb_pl_sysref_gen;
  logic pl_clk = 1'b0;
  logic pl_rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [7:0] cfg_count = '0;
`ifdef SYSREF_ALIGN_EN
  logic sysref_ref = 1'b0;
`endif
  logic sysref_out, busy, done;
  logic [7:0] pulse_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    logic so;
    logic bz;
    logic dn;
    logic [7:0] pc;
  } vec_t;
  vec_t tbl[$];
  always #5 pl_clk = ~pl_clk;
  pl_sysref_gen dut (
    .pl_clk(pl_clk),
    .pl_rst(pl_rst),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .cfg_count(cfg_count),
    .start(start),
    .stop(stop),
`ifdef SYSREF_ALIGN_EN
    .sysref_ref(sysref_ref),
`endif
    .sysref_out(sysref_out),
    .busy(busy),
    .done(done),
    .pulse_cnt(pulse_cnt)
  );
  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask
  task automatic add(input int c, input logic so, input logic bz, input logic dn, input logic [7:0] pc);
    vec_t v;
    v.cyc = c;
    v.so = so;
    v.bz = bz;
    v.dn = dn;
    v.pc = pc;
    tbl.push_back(v);
  endtask
  task automatic set_cfg(input logic [15:0] p, input logic [15:0] h, input logic [7:0] n);
    cfg_period = p;
    cfg_high = h;
    cfg_count = n;
  endtask
  task automatic burst_tbl(input logic [7:0] pc0);
    add(0, 0, 0, 0, pc0);
    add(1, 1, 1, 0, 1);
    add(3, 1, 1, 0, 1);
    add(4, 0, 1, 0, 1);
    add(10, 0, 1, 0, 1);
    add(11, 1, 1, 0, 2);
    add(21, 1, 1, 0, 3);
    add(31, 1, 1, 0, 4);
    add(33, 1, 1, 0, 4);
    add(34, 0, 1, 0, 4);
    add(40, 0, 1, 0, 4);
    add(41, 0, 0, 1, 4);
    add(42, 0, 0, 0, 4);
    add(43, 0, 0, 0, 4);
  endtask
  task automatic run_seq(input int ncyc, input int start_c, input int start2_c, input int stop_c,
                         input int rst_c, input int alt_c, input int ref_c);
    for (int c = 0; c <= ncyc; c++) begin
      start = (c == start_c) || (c == start2_c);
      stop = (c == stop_c);
      pl_rst = (c == rst_c);
      if (c == alt_c) set_cfg(4, 1, 1);
`ifdef SYSREF_ALIGN_EN
      sysref_ref = (c >= ref_c);
`endif
      foreach (tbl[i]) if (tbl[i].cyc == c) begin
        chk("sysref_out", c, 32'(sysref_out), 32'(tbl[i].so));
        chk("busy", c, 32'(busy), 32'(tbl[i].bz));
        chk("done", c, 32'(done), 32'(tbl[i].dn));
        chk("pulse_cnt", c, 32'(pulse_cnt), 32'(tbl[i].pc));
      end
      @(posedge pl_clk);
      #1;
    end
    start = 1'b0;
    stop = 1'b0;
    pl_rst = 1'b0;
    tbl.delete();
  endtask
  initial begin
    repeat (2) @(posedge pl_clk);
    #1;
    pl_rst = 1'b0;
    chk("rst_sysref_out", 0, 32'(sysref_out), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_done", 0, 32'(done), 0);
    chk("rst_pulse_cnt", 0, 32'(pulse_cnt), 0);
`ifdef SYSREF_ALIGN_EN
    set_cfg(10, 3, 1);
    add(0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0);
    add(9, 0, 1, 0, 0);
    add(10, 1, 1, 0, 1);
    add(12, 1, 1, 0, 1);
    add(13, 0, 1, 0, 1);
    add(20, 0, 0, 1, 1);
    add(21, 0, 0, 0, 1);
    run_seq(22, 0, -1, -1, -1, -1, 7);
    add(1, 0, 1, 0, 0);
    add(3, 0, 1, 0, 0);
    add(4, 0, 0, 1, 0);
    add(5, 0, 0, 0, 0);
    run_seq(6, 0, -1, 3, -1, -1, 1000);
`else
    set_cfg(10, 3, 4);
    burst_tbl(0);
    run_seq(43, 0, -1, -1, -1, -1, 0);
    set_cfg(10, 3, 4);
    burst_tbl(4);
    run_seq(43, 0, 5, -1, -1, 5, 0);
    set_cfg(10, 3, 4);
    add(12, 1, 1, 0, 2);
    add(13, 0, 0, 0, 0);
    add(20, 0, 0, 0, 0);
    run_seq(21, 0, -1, -1, 12, -1, 0);
    burst_tbl(0);
    run_seq(43, 0, -1, -1, -1, -1, 0);
    set_cfg(8, 2, 0);
    add(1, 1, 1, 0, 1);
    add(9, 1, 1, 0, 2);
    add(17, 1, 1, 0, 3);
    add(18, 1, 1, 0, 3);
    add(19, 0, 1, 0, 3);
    add(24, 0, 1, 0, 3);
    add(25, 0, 0, 1, 3);
    add(26, 0, 0, 0, 3);
    run_seq(28, 0, -1, 20, -1, -1, 0);
    set_cfg(1, 0, 0);
    add(1, 1, 1, 0, 1);
    add(2, 0, 1, 0, 1);
    add(3, 1, 1, 0, 2);
    add(4, 0, 1, 0, 2);
    add(7, 1, 1, 0, 4);
    add(8, 0, 1, 0, 4);
    add(9, 0, 0, 1, 4);
    run_seq(11, 0, -1, 6, -1, -1, 0);
    set_cfg(5, 9, 2);
    add(1, 1, 1, 0, 1);
    add(4, 1, 1, 0, 1);
    add(5, 0, 1, 0, 1);
    add(6, 1, 1, 0, 2);
    add(9, 1, 1, 0, 2);
    add(10, 0, 1, 0, 2);
    add(11, 0, 0, 1, 2);
    add(12, 0, 0, 0, 2);
    run_seq(13, 0, -1, -1, -1, -1, 0);
    set_cfg(4, 2, 1);
    add(1, 0, 0, 0, 2);
    add(2, 0, 0, 0, 2);
    add(5, 0, 0, 0, 2);
    run_seq(6, 0, -1, 0, -1, -1, 0);
    set_cfg(4, 2, 1);
    add(1, 1, 1, 0, 1);
    add(2, 1, 1, 0, 1);
    add(3, 0, 1, 0, 1);
    add(5, 0, 0, 1, 1);
    add(6, 1, 1, 0, 1);
    add(10, 0, 0, 1, 1);
    add(11, 0, 0, 0, 1);
    run_seq(12, 0, 5, -1, -1, -1, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
